// File: rtl/cbb_ecc_pkg.sv
// Shared types and helpers for the ECC error-logging slice.
package cbb_ecc_pkg;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_SEC  = 2'b01,
      ERR_DED  = 2'b10
   } err_type_e;

   // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val >= max_v) ? max_v : (val + 32'd1);
   endfunction

endpackage

// File: rtl/cbb_sync_fifo.sv
// Single-clock FIFO with registered-head read; push while full is taken only alongside a pop.
module cbb_sync_fifo
   import cbb_ecc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= din;
   end

endmodule

// File: rtl/cbb_ecc_err_log.sv
// SECDED error logger: counters, first-error record, irq and optional scrub queue.
// Scrub queue and overflow flag are built only when CBB_ECC_ERR_LOG_SCRUB_EN is defined.
module cbb_ecc_err_log
   import cbb_ecc_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter int CW = 16,
   parameter int QD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd_vld,
   input  logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] dec_dout,
   input  logic          dec_sec,
   input  logic          dec_ded,
   input  logic          clr,
   input  logic [CW-1:0] sec_thr,
   output logic [CW-1:0] sec_cnt,
   output logic [CW-1:0] ded_cnt,
   output logic          err_vld,
   output logic [1:0]    err_type,
   output logic [AW-1:0] err_addr,
   output logic          irq,
   output logic          scrub_vld,
   output logic [AW-1:0] scrub_addr,
   output logic [DW-1:0] scrub_data,
   input  logic          scrub_rdy,
   output logic          scrub_ovf
);

   logic          vld_p1_q, vld_p1_d;
   logic [AW-1:0] addr_p1_q, addr_p1_d;
   logic [CW-1:0] sec_cnt_q, sec_cnt_d;
   logic [CW-1:0] ded_cnt_q, ded_cnt_d;
   logic          err_vld_q, err_vld_d;
   err_type_e     err_type_q, err_type_d;
   logic [AW-1:0] err_addr_q, err_addr_d;
   logic          irq_q, irq_d;
   logic          sec_evt, ded_evt;

   // s1: the decoder flags arrive one cycle after rd_vld, so the address is delayed to match.
   assign vld_p1_d  = rd_vld;
   assign addr_p1_d = rd_addr;

   assign ded_evt = vld_p1_q & dec_ded;
   assign sec_evt = vld_p1_q & dec_sec & ~dec_ded;

   always_comb begin
      sec_cnt_d  = sec_cnt_q;
      ded_cnt_d  = ded_cnt_q;
      err_vld_d  = err_vld_q;
      err_type_d = err_type_q;
      err_addr_d = err_addr_q;
      if (clr) begin
         sec_cnt_d  = '0;
         ded_cnt_d  = '0;
         err_vld_d  = 1'b0;
         err_type_d = ERR_NONE;
         err_addr_d = '0;
      end else begin
         if (sec_evt) sec_cnt_d = CW'(sat_inc(32'(sec_cnt_q), CW));
         if (ded_evt) ded_cnt_d = CW'(sat_inc(32'(ded_cnt_q), CW));
         // A DED may replace a held SEC once; a held DED is final.
         if ((sec_evt || ded_evt) && !err_vld_q) begin
            err_vld_d  = 1'b1;
            err_type_d = ded_evt ? ERR_DED : ERR_SEC;
            err_addr_d = addr_p1_q;
         end else if (ded_evt && err_type_q == ERR_SEC) begin
            err_type_d = ERR_DED;
            err_addr_d = addr_p1_q;
         end
      end
      irq_d = (ded_cnt_q != '0) | ((sec_thr != '0) & (sec_cnt_q >= sec_thr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q   <= 1'b0;
         sec_cnt_q  <= '0;
         ded_cnt_q  <= '0;
         err_vld_q  <= 1'b0;
         err_type_q <= ERR_NONE;
         err_addr_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         vld_p1_q   <= vld_p1_d;
         sec_cnt_q  <= sec_cnt_d;
         ded_cnt_q  <= ded_cnt_d;
         err_vld_q  <= err_vld_d;
         err_type_q <= err_type_d;
         err_addr_q <= err_addr_d;
         irq_q      <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_p1_q <= addr_p1_d;
   end

   assign sec_cnt  = sec_cnt_q;
   assign ded_cnt  = ded_cnt_q;
   assign err_vld  = err_vld_q;
   assign err_type = err_type_q;
   assign err_addr = err_addr_q;
   assign irq      = irq_q;

`ifdef CBB_ECC_ERR_LOG_SCRUB_EN
   logic             q_full, q_empty, q_pop, q_drop;
   logic [AW+DW-1:0] q_dout;
   logic             scrub_ovf_q, scrub_ovf_d;

   assign q_pop  = ~q_empty & scrub_rdy;
   assign q_drop = sec_evt & q_full & ~q_pop;

   // clr does not gate the push: the queue keeps corrected data even when logging is cleared.
   cbb_sync_fifo #(
      .WIDTH (AW + DW),
      .DEPTH (QD)
   ) u_scrub_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (sec_evt),
      .din   ({addr_p1_q, dec_dout}),
      .pop   (q_pop),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty)
   );

   always_comb begin
      scrub_ovf_d = scrub_ovf_q;
      if (clr)         scrub_ovf_d = 1'b0;
      else if (q_drop) scrub_ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scrub_ovf_q <= 1'b0;
      else        scrub_ovf_q <= scrub_ovf_d;
   end

   assign scrub_vld  = ~q_empty;
   assign scrub_addr = q_empty ? '0 : q_dout[AW+DW-1:DW];
   assign scrub_data = q_empty ? '0 : q_dout[DW-1:0];
   assign scrub_ovf  = scrub_ovf_q;
`else
   logic unused_scrub;
   assign unused_scrub = ^{scrub_rdy, dec_dout};

   assign scrub_vld  = 1'b0;
   assign scrub_addr = '0;
   assign scrub_data = '0;
   assign scrub_ovf  = 1'b0;
`endif

endmodule

// File: doc/cbb_ecc_err_log.md
# cbb_ecc_err_log

SECDED error logger and scrub-request queue that sits directly downstream of the SECDED decoder (`cbb_ecc_dec`) on an ECC-protected SRAM read path. It aligns the read address with the decoder's one-cycle-late `sec`/`ded` flags, keeps saturating error counters, captures the first error record, and raises an interrupt. Optionally it queues corrected words so a write-back agent can scrub single-bit errors from the array.

## Interface
Parameters:
- `AW`, 10, read address width
- `DW`, 32, data width; must match the decoder's `DW`
- `CW`, 16, error counter width
- `QD`, 4, scrub queue depth; power of two, ≥2

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `rd_vld`  in  1  read word presented to the decoder's `din` this cycle
- `rd_addr`  in  AW  address of that read
- `dec_dout`  in  DW  decoder corrected data; valid the cycle after `rd_vld`
- `dec_sec`  in  1  decoder single-error-corrected flag; valid the cycle after `rd_vld`
- `dec_ded`  in  1  decoder double-error-detected flag; valid the cycle after `rd_vld`
- `clr`  in  1  single-cycle pulse; clears counters, record, overflow and irq
- `sec_thr`  in  CW  SEC interrupt threshold; 0 disables the SEC interrupt term
- `sec_cnt`  out  CW  saturating SEC event count
- `ded_cnt`  out  CW  saturating DED event count
- `err_vld`  out  1  sticky flag: an error record is held
- `err_type`  out  2  held record type: 01 = SEC, 10 = DED
- `err_addr`  out  AW  address of the held record
- `irq`  out  1  level interrupt
- `scrub_vld`  out  1  scrub request valid
- `scrub_addr`  out  AW  address to rewrite
- `scrub_data`  out  DW  corrected data to rewrite
- `scrub_rdy`  in  1  scrub consumer ready
- `scrub_ovf`  out  1  sticky flag: a scrub request was dropped

All outputs reset to 0.

## Operation
- Stage s1 registers `rd_vld` and `rd_addr` each cycle. An event is evaluated only when s1 is valid, using the `dec_*` inputs in that cycle.
- Event classification:
  - `dec_ded` = 1 is a DED event, regardless of `dec_sec`.
  - `dec_sec` = 1 with `dec_ded` = 0 is a SEC event.
  - Both flags 0 is no event.
  - When s1 is invalid, `dec_*` are ignored.
- Counters increment by 1 per event and saturate at all-ones.
- Error record:
  - When `err_vld` = 0, any event loads {type, addr} and sets `err_vld`.
  - When a SEC record is held, a DED event overwrites it once.
  - A held DED record is never overwritten.
- `irq` is registered: `irq` = (`ded_cnt` ≠ 0) | (`sec_thr` ≠ 0 & `sec_cnt` ≥ `sec_thr`).
- Scrub queue:
  - Each SEC event pushes {s1 addr, `dec_dout`}. DED events never push.
  - A pop occurs on `scrub_vld` & `scrub_rdy`.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the push is dropped and `scrub_ovf` is set.
  - Push and pop in the same cycle with the queue empty: the entry is not bypassed; it appears on the next cycle.
  - `scrub_addr`/`scrub_data` stay stable while `scrub_vld` & !`scrub_rdy`.
- `clr` handling:
  - `clr` has priority over a same-cycle event for counters, record and `scrub_ovf`; that event is not logged.
  - The same-cycle SEC push still enters the queue.
  - `clr` never flushes the queue.
- Reset mid-operation returns all state to its reset value; queue contents are lost.

## Timing
- Cycle T: `rd_vld` = 1. Cycle T+1: `dec_*` valid and the event is evaluated.
- Cycle T+2: counters, record, `scrub_ovf` and the queue head (`scrub_vld`) are visible.
- Cycle T+3: `irq` is visible.
- After a `clr` pulse at cycle C: counters, record and `scrub_ovf` read 0 at C+1; `irq` is low at C+2.
- Back-to-back `rd_vld` at full rate is supported with no bubbles.
- Queue throughput is one push and one pop per cycle.

## Configuration
- Macro: `CBB_ECC_ERR_LOG_SCRUB_EN`.
- Defined: the scrub queue and `scrub_ovf` logic are present, as specified above.
- Undefined:
  - No queue storage is built.
  - `scrub_vld`, `scrub_addr`, `scrub_data` and `scrub_ovf` are tied to 0.
  - `scrub_rdy` is ignored.
  - SEC events are logged only.

## Structure
- Package `cbb_ecc_pkg` holds:
  - error-type constants: ERR_NONE = 2'b00, ERR_SEC = 2'b01, ERR_DED = 2'b10
  - a saturating-increment function
- Sub-module `cbb_sync_fifo` (params WIDTH, DEPTH; push/pop/full/empty) implements the scrub queue. It is instantiated only under `CBB_ECC_ERR_LOG_SCRUB_EN`.

## Test plan
- Clean reads: 8 reads with `dec_sec` = `dec_ded` = 0 → counters 0, `err_vld` 0, `irq` 0, `scrub_vld` 0.
- Single SEC at addr 0x2A with `dec_dout` = 0xDEADBEEF → at T+2: `sec_cnt` = 1, `err_type` = 01, `err_addr` = 0x2A; `scrub_vld` = 1 with {0x2A, 0xDEADBEEF}. With `sec_thr` = 1 → `irq` = 1 at T+3.
- Upgrade: SEC at 0x10, then DED at 0x20, then SEC at 0x30 → record {10, 0x20}, `sec_cnt` = 2, `ded_cnt` = 1, `irq` = 1.
- Overflow: `scrub_rdy` = 0 and QD+1 = 5 SEC events → 4 entries queued, `scrub_ovf` = 1. Then `scrub_rdy` = 1 → addresses drain in push order over 4 cycles.
- Saturation and clear: `CW` = 4, 20 SEC events → `sec_cnt` = 15. `clr` coincident with a SEC event → `sec_cnt` = 0 at C+1, that event's push is still queued, `irq` = 0 at C+2.
- Reset mid-burst: `rst_n` low during back-to-back SEC reads → all outputs 0 immediately, and no stale event after release.
